hazard_control_unit: RTL
========================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- MEM_TIMEOUT, 15, maximum consecutive data-memory not-ready cycles.
- CNT_W, 16, stall counter width.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- ID_EX_MemRead  in  1  EX-stage instruction is a load.
- ID_EX_RegisterRd  in  4  EX-stage destination register.
- IF_ID_RegisterRs  in  4  ID-stage source 1.
- IF_ID_RegisterRt  in  4  ID-stage source 2.
- IF_ID_UsesRt  in  1  ID-stage instruction reads Rt.
- ID_Halt  in  1  HLT decoded in ID.
- Branch_taken  in  1  taken branch resolved in EX.
- mem_req  in  1  MEM-stage data-memory access active.
- mem_ready  in  1  data memory completes this cycle.
- PC_write  out  1  PC load enable.
- IF_ID_write  out  1  IF/ID enable.
- IF_ID_flush  out  1  IF/ID to NOP.
- ID_EX_write  out  1  ID/EX enable.
- ID_EX_flush  out  1  ID/EX to NOP.
- EX_MEM_write  out  1  EX/MEM enable.
- MEM_WB_bubble  out  1  MEM/WB loads NOP.
- halted  out  1  processor stopped.
- mem_err  out  1  memory timeout occurred.
- stall_cnt  out  CNT_W  stalled-cycle count.

Function
REQ-004 The block SHALL implement a state machine with states RUN, MEM_WAIT, DRAIN and HALTED.
REQ-005 The block SHALL define the following terms:
- mem_stall = mem_req & ~mem_ready.
- load_use = ID_EX_MemRead & (ID_EX_RegisterRd != 0) & ((ID_EX_RegisterRd == IF_ID_RegisterRs) | (IF_ID_UsesRt & ID_EX_RegisterRd == IF_ID_RegisterRt)).

REQ-006 Outside HALTED, absent any hazard, the block SHALL drive all write enables to 1 and all flushes and MEM_WB_bubble to 0; outputs are combinational from state and inputs (zero-cycle latency).
REQ-007 Per-cycle priority SHALL be: mem_stall (freeze) > Branch_taken (flush) > ID_Halt (DRAIN entry) > load_use (bubble).
REQ-008 Freeze SHALL drive PC_write, IF_ID_write, ID_EX_write and EX_MEM_write to 0, and MEM_WB_bubble to 1.
REQ-009 Flush SHALL drive PC_write=1, IF_ID_flush=1 and ID_EX_flush=1.
REQ-010 The load_use bubble SHALL drive PC_write=0, IF_ID_write=0 and ID_EX_flush=1 for exactly one cycle per detected hazard.
REQ-011 In RUN, mem_stall SHALL cause a transition to MEM_WAIT.
REQ-012 In RUN, ID_Halt without mem_stall or Branch_taken SHALL cause a transition to DRAIN, with PC_write=0, IF_ID_write=0 and ID_EX_flush=1 in that cycle.
REQ-013 In MEM_WAIT, the block SHALL freeze while mem_stall is true.
REQ-014 In MEM_WAIT, the cycle mem_ready=1 SHALL be evaluated with RUN rules, and the next state SHALL be RUN (or DRAIN per REQ-012).
REQ-015 A timeout counter SHALL count consecutive mem_stall cycles in RUN, MEM_WAIT and DRAIN, and SHALL clear on any cycle without mem_stall.
REQ-016 When the timeout count reaches MEM_TIMEOUT with mem_stall still true, the next state SHALL be HALTED and mem_err SHALL be set (sticky).
REQ-017 In DRAIN, the block SHALL drive PC_write=0, IF_ID_write=0 and ID_EX_flush=1 every cycle.
REQ-018 A 2-bit drain counter, cleared on DRAIN entry, SHALL increment only on non-frozen DRAIN cycles; the count value 2 without mem_stall SHALL cause a transition to HALTED, giving 3 drain cycles.
REQ-019 In DRAIN, Branch_taken without mem_stall SHALL apply flush and return the block to RUN, abandoning the halt.
REQ-020 In DRAIN, mem_stall SHALL freeze and hold the drain counter.
REQ-021 HALTED SHALL be terminal until reset: all write enables 0, flushes 0, MEM_WB_bubble=1, halted=1, all inputs ignored.
REQ-022 stall_cnt SHALL increment by 1 on each cycle in which PC_write=0 outside HALTED, and SHALL saturate at all-ones.

Reset
REQ-023 While rst_n=0, the block SHALL be in RUN with all write enables 0, flushes 0, MEM_WB_bubble 0, halted 0, mem_err 0, stall_cnt 0, and the timeout and drain counters 0.
REQ-024 Deassertion of rst_n SHALL be the only exit from HALTED.
REQ-025 Reset asserted mid-MEM_WAIT or mid-DRAIN SHALL abort the operation immediately, with no pending state retained.

Verification
REQ-026 The bench SHALL cover the load-use case: ID_EX_MemRead=1, ID_EX_RegisterRd=5, IF_ID_RegisterRs=5 -> one cycle PC_write=0, IF_ID_write=0, ID_EX_flush=1, then stall_cnt=1. The same stimulus with Rd=0, or with a Rt-only match and IF_ID_UsesRt=0, -> no stall.
REQ-027 The bench SHALL cover the memory-wait case: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 -> freeze for 4 cycles, normal enables on the 5th cycle, state RUN, stall_cnt=4.
REQ-028 The bench SHALL cover the timeout case: mem_req=1, mem_ready=0 held for 15 cycles -> halted=1 and mem_err=1 after the 15th edge; a subsequent mem_ready=1 -> no change.
REQ-029 The bench SHALL cover simultaneous events: Branch_taken=1 with load_use=1 -> flush only (PC_write=1). Branch_taken=1 with mem_stall -> freeze only, and the flush applies in the cycle mem_ready=1 while Branch_taken is still held.
REQ-030 The bench SHALL cover halt and halt cancellation: ID_Halt pulse -> 3 DRAIN cycles, then halted=1. ID_Halt followed by Branch_taken in the 2nd DRAIN cycle -> flush, RUN, halted stays 0.
REQ-031 The bench SHALL cover reset mid-operation: rst_n pulled low during MEM_WAIT (timeout count 10) -> outputs immediately at reset values; after release, a new 15-cycle stall is required to time out.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use bubbles, branch flushes, data-memory freeze
// with timeout, and a three-cycle drain before halting.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_MemRead,
  input  logic [3:0]       ID_EX_RegisterRd,
  input  logic [3:0]       IF_ID_RegisterRs,
  input  logic [3:0]       IF_ID_RegisterRt,
  input  logic             IF_ID_UsesRt,
  input  logic             ID_Halt,
  input  logic             Branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             MEM_WB_bubble,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_HALTED   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [1:0]       drn_q, drn_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic mem_stall, load_use, to_hit;
  logic pc_c, ifw_c, iff_c, idw_c, idf_c, exw_c, bub_c;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ID_EX_MemRead & (ID_EX_RegisterRd != 4'd0) &
                     ((ID_EX_RegisterRd == IF_ID_RegisterRs) |
                      (IF_ID_UsesRt & (ID_EX_RegisterRd == IF_ID_RegisterRt)));
  // This cycle is the MEM_TIMEOUT-th consecutive stall.
  assign to_hit    = mem_stall && ((int'(to_q) + 1) >= MEM_TIMEOUT);

  always_comb begin
    pc_c    = 1'b1;
    ifw_c   = 1'b1;
    iff_c   = 1'b0;
    idw_c   = 1'b1;
    idf_c   = 1'b0;
    exw_c   = 1'b1;
    bub_c   = 1'b0;
    state_d = state_q;
    to_d    = '0;
    drn_d   = drn_q;
    err_d   = err_q;
    if (state_q == S_HALTED) begin
      pc_c  = 1'b0;
      ifw_c = 1'b0;
      idw_c = 1'b0;
      exw_c = 1'b0;
      bub_c = 1'b1;
    end else if (mem_stall) begin
      pc_c  = 1'b0;
      ifw_c = 1'b0;
      idw_c = 1'b0;
      exw_c = 1'b0;
      bub_c = 1'b1;
      if (to_hit) begin
        state_d = S_HALTED;
        err_d   = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
        // A frozen drain keeps its place; only RUN parks in MEM_WAIT.
        if (state_q != S_DRAIN) state_d = S_MEM_WAIT;
      end
    end else if (Branch_taken) begin
      iff_c   = 1'b1;
      idf_c   = 1'b1;
      state_d = S_RUN;
    end else if (state_q == S_DRAIN) begin
      pc_c  = 1'b0;
      ifw_c = 1'b0;
      idf_c = 1'b1;
      if (drn_q == 2'd2) state_d = S_HALTED;
      else               drn_d   = drn_q + 2'd1;
    end else if (ID_Halt) begin
      pc_c    = 1'b0;
      ifw_c   = 1'b0;
      idf_c   = 1'b1;
      state_d = S_DRAIN;
      drn_d   = 2'd0;
    end else begin
      if (load_use) begin
        pc_c  = 1'b0;
        ifw_c = 1'b0;
        idf_c = 1'b1;
      end
      state_d = S_RUN;
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    if (state_q != S_HALTED && !pc_c && scnt_q != {CNT_W{1'b1}})
      scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      to_q    <= '0;
      drn_q   <= '0;
      err_q   <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      drn_q   <= drn_d;
      err_q   <= err_d;
      scnt_q  <= scnt_d;
    end
  end

  // Reset forces every control low immediately, independent of the clock.
  assign PC_write      = rst_n & pc_c;
  assign IF_ID_write   = rst_n & ifw_c;
  assign IF_ID_flush   = rst_n & iff_c;
  assign ID_EX_write   = rst_n & idw_c;
  assign ID_EX_flush   = rst_n & idf_c;
  assign EX_MEM_write  = rst_n & exw_c;
  assign MEM_WB_bubble = rst_n & bub_c;
  assign halted        = rst_n & (state_q == S_HALTED);
  assign mem_err       = err_q;
  assign stall_cnt     = scnt_q;
endmodule
